// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcode/funct
// constants, ALU operation codes and the strobe bundle driven by the decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       ext_op;
    } ctrl_t;

    function automatic logic funct_ok(input logic [5:0] f);
        return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore strobe decode: maps the current state (plus the latched opcode for the
// immediate ops) to the datapath control bundle.
import mips_ctrl_pkg::*;

module mc_out_decode (
    input  logic [3:0] state,
    input  logic [5:0] op_latched,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    state_t st;
    assign st = state_t'(state);

    always_comb begin
        ctrl = '0;
        case (st)
            S_FETCH: begin
                // Fetch strobes only fire on the cycle the memory completes.
                ctrl.alu_src_b = 2'b01;
                ctrl.mem_read  = mem_ready;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.ext_op    = 1'b1;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.ext_op    = 1'b1;
            end
            S_MEMRD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            S_IEXEC: begin
                // andi/ori are logical ops on a zero-extended immediate.
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = (op_latched == OP_ADDI) ? ALU_ADD : ALU_LOGIC;
                ctrl.ext_op    = (op_latched == OP_ADDI);
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with bounded memory waits, illegal-instruction
// detection and an opcode latched at DECODE.
import mips_ctrl_pkg::*;

module mips_mc_control #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ext_op,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state
);

    localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t        state_q, state_n;
    logic [5:0]    op_q;
    logic [CW-1:0] wait_cnt;
    logic          waiting, wait_done, timeout_c, illegal_c;
    ctrl_t         dec, out;

    // The branch decision is made in the datapath (pc_write_cond & zero).
    logic unused_zero;
    assign unused_zero = zero;

    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign wait_done = waiting && (wait_cnt == CW'(MEM_WAIT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
            op_q     <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == S_DECODE)
                op_q <= opcode;
            if (state_n != state_q || !waiting || mem_ready || wait_done)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n   = state_q;
        timeout_c = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH:
                if (mem_ready)      state_n = S_DECODE;
                else if (wait_done) timeout_c = 1'b1;
            S_DECODE:
                case (opcode)
                    OP_RTYPE:
                        if (funct_ok(funct)) state_n = S_EXEC;
                        else begin
                            illegal_c = 1'b1;
                            state_n   = S_FETCH;
                        end
                    OP_LW, OP_SW:             state_n = S_MEMADR;
                    OP_BEQ:                   state_n = S_BRANCH;
                    OP_J:                     state_n = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_n = S_IEXEC;
                    default: begin
                        illegal_c = 1'b1;
                        state_n   = S_FETCH;
                    end
                endcase
            S_MEMADR: state_n = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:
                if (mem_ready) state_n = S_MEMWB;
                else if (wait_done) begin
                    timeout_c = 1'b1;
                    state_n   = S_FETCH;
                end
            S_MEMWR:
                if (mem_ready) state_n = S_FETCH;
                else if (wait_done) begin
                    timeout_c = 1'b1;
                    state_n   = S_FETCH;
                end
            S_EXEC:  state_n = S_RWB;
            S_IEXEC: state_n = S_IWB;
            default: state_n = S_FETCH;
        endcase
    end

    mc_out_decode u_dec (
        .state      (state_q),
        .op_latched (op_q),
        .mem_ready  (mem_ready),
        .ctrl       (dec)
    );

    // A timed-out access must not commit, and reset silences everything at once.
    always_comb begin
        out = dec;
        if (timeout_c) begin
            out.mem_read  = 1'b0;
            out.mem_write = 1'b0;
        end
        if (!rst_n)
            out = '0;
    end

    assign pc_write      = out.pc_write;
    assign pc_write_cond = out.pc_write_cond;
    assign i_or_d        = out.i_or_d;
    assign mem_read      = out.mem_read;
    assign mem_write     = out.mem_write;
    assign ir_write      = out.ir_write;
    assign mem_to_reg    = out.mem_to_reg;
    assign reg_dst       = out.reg_dst;
    assign reg_write     = out.reg_write;
    assign alu_src_a     = out.alu_src_a;
    assign alu_src_b     = out.alu_src_b;
    assign alu_op        = out.alu_op;
    assign pc_source     = out.pc_source;
    assign ext_op        = out.ext_op;
    assign illegal       = rst_n & illegal_c;
    assign timeout       = rst_n & timeout_c;
    assign state         = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: per-instruction expected traces built from the
// instruction's state path and wait pattern, applied cycle by cycle.
module tb_mips_mc_control;

    localparam int MAXW = 15;

    logic       clk, rst_n, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op, illegal, timeout;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    mips_mc_control #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .ext_op(ext_op), .illegal(illegal), .timeout(timeout),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector, field order matches expv().
    logic [22:0] act;
    assign act = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, ext_op, illegal, timeout};

    typedef struct {
        logic        mr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [22:0] exp;
        string       tag;
    } ent_t;

    ent_t q[$];
    int   nvec = 0;
    int   nfail = 0;

    // Strobe table per state as the controller is documented to behave.
    function automatic logic [22:0] expv(int st, logic [5:0] iop, logic mr, logic ill, logic tmo);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ext;
        logic [1:0] asb, aop, psrc;
        pcw  = (st == 0 && mr) || st == 9;
        pcwc = (st == 8);
        iord = (st == 3 || st == 5);
        mrd  = ((st == 0 && mr) || st == 3) && !tmo;
        mwr  = (st == 5) && !tmo;
        irw  = (st == 0 && mr);
        m2r  = (st == 4);
        rdst = (st == 7);
        rw   = (st == 4 || st == 7 || st == 11);
        asa  = (st == 2 || st == 6 || st == 8 || st == 10);
        asb  = (st == 0) ? 2'd1 : (st == 1) ? 2'd3 : (st == 2 || st == 10) ? 2'd2 : 2'd0;
        aop  = (st == 6) ? 2'd2 : (st == 8) ? 2'd1 : (st == 10 && iop != 6'h08) ? 2'd3 : 2'd0;
        psrc = (st == 8) ? 2'd1 : (st == 9) ? 2'd2 : 2'd0;
        ext  = (st == 1 || st == 2 || (st == 10 && iop == 6'h08));
        return {4'(st), pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ext, ill, tmo};
    endfunction

    task automatic add(input logic mr, input logic [5:0] op, input logic [5:0] fn, input int st,
                       input logic [5:0] iop, input logic ill, input logic tmo, input string tag);
        ent_t e;
        e.mr = mr; e.op = op; e.fn = fn; e.tag = tag;
        e.exp = expv(st, iop, mr, ill, tmo);
        q.push_back(e);
    endtask

    // Memory-wait state: wm idle cycles then ready, or a timeout once the budget runs out.
    task automatic mem_wait(input int st, input logic [5:0] iop, input int wm, input string tag,
                            output bit to);
        to = 1'b0;
        for (int i = 0; i < wm; i++) begin
            if (i == MAXW) begin
                add(1'b0, 6'($urandom), 6'($urandom), st, iop, 1'b0, 1'b1, tag);
                to = 1'b1;
                return;
            end
            add(1'b0, 6'($urandom), 6'($urandom), st, iop, 1'b0, 1'b0, tag);
        end
        add(1'b1, 6'($urandom), 6'($urandom), st, iop, 1'b0, 1'b0, tag);
    endtask

    // Expected trace of one instruction; opcode is scrambled after DECODE.
    task automatic build(input logic [5:0] iop, input logic [5:0] fn, input int wf, input int wm,
                         input string tag);
        bit bad, to;
        for (int i = 0; i < wf; i++)
            add(1'b0, iop, fn, 0, iop, 1'b0, (i % (MAXW + 1)) == MAXW, tag);
        add(1'b1, iop, fn, 0, iop, 1'b0, 1'b0, tag);
        bad = !(iop inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D}) ||
              (iop == 6'h00 && !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}));
        add(1'($urandom), iop, fn, 1, iop, bad, 1'b0, tag);
        if (bad) return;
        case (iop)
            6'h00: begin
                add(1'($urandom), 6'($urandom), 6'($urandom), 6, iop, 1'b0, 1'b0, tag);
                add(1'($urandom), 6'($urandom), 6'($urandom), 7, iop, 1'b0, 1'b0, tag);
            end
            6'h23: begin
                add(1'($urandom), 6'($urandom), 6'($urandom), 2, iop, 1'b0, 1'b0, tag);
                mem_wait(3, iop, wm, tag, to);
                if (!to) add(1'($urandom), 6'($urandom), 6'($urandom), 4, iop, 1'b0, 1'b0, tag);
            end
            6'h2B: begin
                add(1'($urandom), 6'($urandom), 6'($urandom), 2, iop, 1'b0, 1'b0, tag);
                mem_wait(5, iop, wm, tag, to);
            end
            6'h04: add(1'($urandom), 6'($urandom), 6'($urandom), 8, iop, 1'b0, 1'b0, tag);
            6'h02: add(1'($urandom), 6'($urandom), 6'($urandom), 9, iop, 1'b0, 1'b0, tag);
            default: begin
                add(1'($urandom), 6'($urandom), 6'($urandom), 10, iop, 1'b0, 1'b0, tag);
                add(1'($urandom), 6'($urandom), 6'($urandom), 11, iop, 1'b0, 1'b0, tag);
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [22:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b want %b", tag, act, exp);
        end
    endtask

    // Entered at posedge+1; each record is driven, checked mid-cycle, then clocked.
    task automatic run_q();
        foreach (q[i]) begin
            mem_ready = q[i].mr;
            opcode    = q[i].op;
            funct     = q[i].fn;
            @(negedge clk);
            chk($sformatf("%s step %0d", q[i].tag, i), q[i].exp);
            @(posedge clk);
            #1;
        end
        q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [5:0] pool [11];
        logic [5:0] op, fn;
        rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b1; opcode = 6'h23; funct = 6'h20;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 23'h0);
        rst_n = 1'b1;

        build(6'h23, 6'h00, 0, 0,  "lw");
        build(6'h0D, 6'h00, 0, 0,  "ori");
        build(6'h08, 6'h00, 0, 0,  "addi");
        build(6'h0C, 6'h00, 0, 0,  "andi");
        build(6'h00, 6'h20, 0, 0,  "add");
        build(6'h00, 6'h2A, 1, 0,  "slt");
        build(6'h04, 6'h00, 0, 0,  "beq");
        build(6'h02, 6'h00, 0, 0,  "j");
        build(6'h2B, 6'h00, 0, 3,  "sw_wait3");
        build(6'h00, 6'h22, 18, 0, "fetch_timeout");
        build(6'h3F, 6'h00, 0, 0,  "illegal_op");
        build(6'h00, 6'h03, 0, 0,  "illegal_funct");
        build(6'h23, 6'h00, 0, MAXW, "lw_ready_priority");
        build(6'h2B, 6'h00, 0, MAXW + 1, "sw_timeout");
        build(6'h23, 6'h00, 2, MAXW + 1, "lw_timeout");
        build(6'h2B, 6'h00, 0, 0,  "sw");
        run_q();

        // Reset asserted in the middle of RWB.
        build(6'h00, 6'h25, 0, 0, "rwb");
        void'(q.pop_back());
        run_q();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rwb_before_reset", expv(7, 6'h00, 1'b0, 1'b0, 1'b0));
        #1 rst_n = 1'b0;
        #1 chk("rwb_reset_async", 23'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        build(6'h02, 6'h00, 1, 0, "after_reset");
        run_q();

        pool = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h3F, 6'h15};
        repeat (40) begin
            op = pool[$urandom_range(0, 10)];
            fn = 6'($urandom);
            if (op == 6'h00 && $urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 4))
                    0: fn = 6'h20;
                    1: fn = 6'h22;
                    2: fn = 6'h24;
                    3: fn = 6'h25;
                    default: fn = 6'h2A;
                endcase
            end
            build(op, fn, $urandom_range(0, 3),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 3),
                  "random");
        end
        run_q();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, meaning cycles a memory state waits for mem_ready before setting timeout.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instruction bits [5:0]; affects only the illegal check.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory handshake; access completes on the cycle it is high.
REQ-008 SHALL have outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, each 1-bit, meaning the classic multicycle MIPS strobes.
REQ-009 SHALL have outputs alu_src_b, alu_op and pc_source, each 2-bit.
REQ-010 SHALL have output ext_op  1  immediate-extender mode: 1 = sign-extend 16 to 32 bits, 0 = zero-extend.
REQ-011 SHALL have outputs illegal  1  and timeout  1, each a one-cycle pulse.
REQ-012 SHALL have output state  4  current FSM state code, for debug.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10 and IWB=11.
REQ-014 SHALL run FETCH with mem_read=1, ir_write=1, alu_src_b=01, pc_write=1; all three strobes SHALL be asserted only on the mem_ready cycle, and the FSM SHALL otherwise hold in FETCH.
REQ-015 SHALL run DECODE with alu_src_b=11 and ext_op=1, then dispatch on opcode: 0x00→EXEC, 0x23 or 0x2B→MEMADR, 0x04→BRANCH, 0x02→JUMP, 0x08, 0x0C or 0x0D→IEXEC, any other opcode→FETCH with illegal pulsed.
REQ-016 SHALL pulse illegal and return to FETCH when opcode=0x00 and funct is not in {0x20, 0x22, 0x24, 0x25, 0x2A}.
REQ-017 SHALL run MEMADR with alu_src_a=1, alu_src_b=10 and ext_op=1, then go to MEMRD for 0x23 or MEMWR for 0x2B.
REQ-018 SHALL run MEMRD with i_or_d=1 and mem_read=1, holding until mem_ready, then go to MEMWB.
REQ-019 SHALL run MEMWB with reg_write=1 and mem_to_reg=1, then go to FETCH.
REQ-020 SHALL run MEMWR with i_or_d=1 and mem_write=1, holding until mem_ready, then go to FETCH.
REQ-021 SHALL run EXEC with alu_src_a=1 and alu_op=10, then go to RWB; RWB SHALL drive reg_dst=1 and reg_write=1, then go to FETCH.
REQ-022 SHALL run BRANCH with alu_src_a=1, alu_op=01, pc_write_cond=1 and pc_source=01, then go to FETCH; the PC update SHALL be gated externally by zero.
REQ-023 SHALL run JUMP with pc_write=1 and pc_source=10, then go to FETCH.
REQ-024 SHALL run IEXEC with alu_src_a=1, alu_src_b=10, alu_op=00 for addi and 11 for andi/ori, and ext_op=1 only for addi (andi/ori zero-extend); IWB SHALL drive reg_write=1 and reg_dst=0, then go to FETCH.
REQ-025 SHALL drive every output not named for a state to 0, including ext_op.
REQ-026 SHALL count wait cycles in FETCH, MEMRD and MEMWR; when the count reaches MEM_WAIT_MAX without mem_ready, it SHALL pulse timeout and go to FETCH with no strobe asserted; the counter SHALL clear on every state change.
REQ-027 SHALL let mem_ready take priority when it is high on the same cycle the count reaches MEM_WAIT_MAX, completing the access with no timeout.
REQ-028 SHALL register opcode at DECODE; later states SHALL use the latched copy, so opcode changes after DECODE have no effect.
REQ-029 SHALL execute an instruction in: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi/andi/ori 4, counting with mem_ready always high.

Reset
REQ-030 SHALL, while rst_n=0, force state=FETCH, the wait counter to 0, the latched opcode to 0, and every output to 0, independent of clk.
REQ-031 SHALL, when rst_n asserts mid-instruction, abort immediately with no further write strobes; the first cycle after release SHALL be FETCH.

Structure
REQ-032 SHALL place state codes, opcode/funct constants and alu_op codes in shared package mips_ctrl_pkg.
REQ-033 SHALL split the combinational state-to-strobe decode into sub-module mc_out_decode, with ports state, latched opcode and mem_ready.

Verification
REQ-034 SHALL verify lw (opcode 0x23) with mem_ready constantly 1: states 0,1,2,3,4,0; reg_write=1 only in state 4; ext_op=1 in states 1 and 2.
REQ-035 SHALL verify ori (0x0D): IEXEC shows ext_op=0 and alu_op=11; addi (0x08) shows ext_op=1 and alu_op=00.
REQ-036 SHALL verify sw with mem_ready low for 3 cycles in MEMWR: mem_write held high for 4 cycles, then FETCH, timeout=0.
REQ-037 SHALL verify mem_ready held low in FETCH for 16 cycles with MEM_WAIT_MAX=15: one timeout pulse, ir_write never 1.
REQ-038 SHALL verify opcode 0x3F, and separately R-type with funct 0x03: illegal pulses once and FSM returns to FETCH with no reg_write.
REQ-039 SHALL verify rst_n dropped during RWB: reg_write falls the same cycle, state=0, and after release FETCH resumes.
